// File: rtl/div_wb_buffer_if.sv
// Bundle of the divider-result, flush and CDB-side signals around div_wb_buffer.
// The slave modport is the buffer's view; the master modport is the surrounding pipeline's view.
`ifndef ROB_LEN
`define ROB_LEN 16
`endif

interface div_wb_buffer_if #(
    parameter int DEPTH   = 4,
    parameter int ROB_LEN = `ROB_LEN
);
    localparam int IW = $clog2(ROB_LEN);
    localparam int OW = $clog2(DEPTH) + 1;

    logic               div_o_valid;
    logic [IW-1:0]      div_o_rob_idx;
    logic [6:0]         div_o_rd;
    logic [31:0]        div_o_data;
    logic               div_i_ready;
    logic               mispredict;
    logic [ROB_LEN-1:0] flush_mask;
    logic               cdb_req;
    logic               cdb_gnt;
    logic [IW-1:0]      cdb_rob_idx;
    logic [6:0]         cdb_rd;
    logic [31:0]        cdb_data;
    logic [OW-1:0]      occupancy;

    // Handshakes: a result transfers on a rising edge with div_o_valid && div_i_ready;
    // a CDB broadcast transfers on a rising edge with cdb_req && cdb_gnt.
    modport slave (
        input  div_o_valid, div_o_rob_idx, div_o_rd, div_o_data,
        input  mispredict, flush_mask, cdb_gnt,
        output div_i_ready, cdb_req, cdb_rob_idx, cdb_rd, cdb_data, occupancy
    );

    modport master (
        output div_o_valid, div_o_rob_idx, div_o_rd, div_o_data,
        output mispredict, flush_mask, cdb_gnt,
        input  div_i_ready, cdb_req, cdb_rob_idx, cdb_rd, cdb_data, occupancy
    );
endinterface

// File: rtl/div_wb_buffer.sv
// Circular writeback FIFO between the divider result port and the CDB, with mispredict
// squashing of stored and incoming results and one-cycle draining of killed slots.
`ifndef ROB_LEN
`define ROB_LEN 16
`endif

module div_wb_buffer #(
    parameter int DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    div_wb_buffer_if.slave bus
);
    localparam int IW = $clog2(`ROB_LEN);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [IW-1:0]    rob_q  [DEPTH];
    logic [IW-1:0]    rob_d  [DEPTH];
    logic [6:0]       rd_q   [DEPTH];
    logic [6:0]       rd_d   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic not_empty;
    logic head_valid;
    logic head_kill;
    logic req;
    logic pop;
    logic ready;
    logic push;
    logic in_kill;

    // Pop uses only the registered head valid bit and the grant, so div_i_ready never
    // depends on div_o_valid or mispredict. A grant while the head is being squashed
    // simply retires that doomed entry early.
    always_comb begin
        not_empty  = (count_q != '0);
        head_valid = valid_q[head_q];
        head_kill  = bus.mispredict && bus.flush_mask[rob_q[head_q]];
        req        = not_empty && head_valid && !head_kill;
        pop        = not_empty && (!head_valid || bus.cdb_gnt);
        ready      = (count_q != CW'(DEPTH)) || pop;
        push       = bus.div_o_valid && ready;
        in_kill    = bus.mispredict && bus.flush_mask[bus.div_o_rob_idx];
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i] && !(bus.mispredict && bus.flush_mask[rob_q[i]]);
            rob_d[i]   = rob_q[i];
            rd_d[i]    = rd_q[i];
            data_d[i]  = data_q[i];
        end
        if (push) begin
            valid_d[tail_q] = !in_kill;
            rob_d[tail_q]   = bus.div_o_rob_idx;
            rd_d[tail_q]    = bus.div_o_rd;
            data_d[tail_q]  = bus.div_o_data;
        end
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i]  <= '0;
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i]  <= rob_d[i];
                rd_q[i]   <= rd_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign bus.div_i_ready = ready;
    assign bus.cdb_req     = req;
    assign bus.cdb_rob_idx = rob_q[head_q];
    assign bus.cdb_rd      = rd_q[head_q];
    assign bus.cdb_data    = data_q[head_q];
    assign bus.occupancy   = count_q;
endmodule

// File: tb/tb_div_wb_buffer.sv
// Bench for div_wb_buffer: directed scenarios then random traffic, all checked against
// a queue model of surviving/killed entries evaluated once per cycle.
`ifndef ROB_LEN
`define ROB_LEN 16
`endif

module tb_div_wb_buffer;
    localparam int DEPTH = 4;
    localparam int RL    = `ROB_LEN;
    localparam int IW    = $clog2(RL);
    localparam int EW    = 1 + IW + 7 + 32;

    logic clk;
    logic rst;
    logic gnt_en;

    div_wb_buffer_if #(.DEPTH(DEPTH), .ROB_LEN(RL)) bus ();

    div_wb_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // The arbiter only grants a live request.
    assign bus.cdb_gnt = gnt_en && bus.cdb_req;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model entries packed as {alive, rob, rd, data}, oldest first.
    logic [EW-1:0] exp_q[$];
    int n_chk;
    int n_err;
    int dut_bcast;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input logic [IW-1:0] rob, input logic [6:0] rd,
                        input logic [31:0] d, input bit mis, input logic [RL-1:0] mask,
                        input bit g, output bit pushed);
        logic [EW-1:0] h;
        bit req_e, pop_e, rdy_e, push_e, head_alive;
        int sz;
        @(negedge clk);
        sz         = exp_q.size();
        h          = (sz > 0) ? exp_q[0] : '0;
        head_alive = (sz > 0) && h[EW-1];
        req_e      = head_alive && !(mis && mask[h[EW-2 -: IW]]);
        pop_e      = (sz > 0) && (!head_alive || (req_e && g));
        rdy_e      = (sz < DEPTH) || pop_e;
        push_e     = v && rdy_e;

        bus.div_o_valid   = push_e;
        bus.div_o_rob_idx = rob;
        bus.div_o_rd      = rd;
        bus.div_o_data    = d;
        bus.mispredict    = mis;
        bus.flush_mask    = mask;
        gnt_en            = g;
        #1;
        chk("div_i_ready", 64'(bus.div_i_ready), 64'(rdy_e));
        chk("occupancy", 64'(bus.occupancy), 64'(sz));
        chk("cdb_req", 64'(bus.cdb_req), 64'(req_e));
        if (req_e) begin
            chk("cdb_rob_idx", 64'(bus.cdb_rob_idx), 64'(h[EW-2 -: IW]));
            chk("cdb_rd", 64'(bus.cdb_rd), 64'(h[38:32]));
            chk("cdb_data", 64'(bus.cdb_data), 64'(h[31:0]));
        end
        if (bus.cdb_req && bus.cdb_gnt) dut_bcast++;

        // Effects of the coming edge: pop, flush survivors, then append.
        if (pop_e) void'(exp_q.pop_front());
        if (mis) begin
            foreach (exp_q[i]) begin
                if (mask[exp_q[i][EW-2 -: IW]]) exp_q[i][EW-1] = 1'b0;
            end
        end
        if (push_e) exp_q.push_back({!(mis && mask[rob]), rob, rd, d});
        pushed = push_e;
    endtask

    task automatic idle(input int n, input bit g);
        bit p;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0, g, p);
    endtask

    initial begin
        bit p;
        int pushed_n;
        int guard;
        int bc0;
        logic [RL-1:0] m;

        n_chk = 0; n_err = 0; dut_bcast = 0;
        rst = 1'b0; gnt_en = 1'b0;
        bus.div_o_valid = 1'b0; bus.div_o_rob_idx = '0; bus.div_o_rd = '0;
        bus.div_o_data = '0; bus.mispredict = 1'b0; bus.flush_mask = '0;

        // Reset state
        #1;
        chk("rst_ready", 64'(bus.div_i_ready), 64'd1);
        chk("rst_req", 64'(bus.cdb_req), 64'd0);
        chk("rst_rob", 64'(bus.cdb_rob_idx), 64'd0);
        chk("rst_rd", 64'(bus.cdb_rd), 64'd0);
        chk("rst_data", 64'(bus.cdb_data), 64'd0);
        chk("rst_occ", 64'(bus.occupancy), 64'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;

        // Single result into an empty FIFO, grant always on
        step(1'b1, IW'(3), 7'd10, 32'h7, 1'b0, '0, 1'b1, p);
        idle(3, 1'b1);

        // Fill to full with no grant, then open the grant and drain
        for (int i = 0; i < 6; i++) step(1'b1, IW'(i), 7'(20 + i), 32'(i), 1'b0, '0, 1'b0, p);
        idle(6, 1'b1);

        // Wrap-around: ten results, grant every other cycle
        bc0 = dut_bcast; pushed_n = 0; guard = 0;
        while (pushed_n < 10 && guard < 100) begin
            step(1'b1, IW'(pushed_n + 5), 7'(pushed_n), 32'hA000 + 32'(pushed_n), 1'b0, '0,
                 guard[0], p);
            if (p) pushed_n++;
            guard++;
        end
        idle(8, 1'b1);
        chk("wrap_pushes", 64'(pushed_n), 64'd10);
        chk("wrap_bcast", 64'(dut_bcast - bc0), 64'd10);

        // Flush of stored entries: rob 1 survives, 2 and 5 killed
        step(1'b1, IW'(1), 7'd1, 32'h11, 1'b0, '0, 1'b0, p);
        step(1'b1, IW'(2), 7'd2, 32'h22, 1'b0, '0, 1'b0, p);
        step(1'b1, IW'(5), 7'd5, 32'h55, 1'b0, '0, 1'b0, p);
        m = '0; m[2] = 1'b1; m[5] = 1'b1;
        step(1'b0, '0, '0, '0, 1'b1, m, 1'b0, p);
        bc0 = dut_bcast;
        idle(4, 1'b1);
        chk("flush_bcast", 64'(dut_bcast - bc0), 64'd1);

        // Flush coincident with a push and a granted head of the same rob
        step(1'b1, IW'(4), 7'd40, 32'h44, 1'b0, '0, 1'b0, p);
        m = '0; m[4] = 1'b1;
        bc0 = dut_bcast;
        step(1'b1, IW'(4), 7'd41, 32'h45, 1'b1, m, 1'b1, p);
        idle(4, 1'b1);
        chk("kill_bcast", 64'(dut_bcast - bc0), 64'd0);

        // Asynchronous reset with three entries stored
        for (int i = 0; i < 3; i++) step(1'b1, IW'(i + 8), 7'(i), 32'(i), 1'b0, '0, 1'b0, p);
        @(negedge clk);
        bus.div_o_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req", 64'(bus.cdb_req), 64'd0);
        chk("arst_occ", 64'(bus.occupancy), 64'd0);
        chk("arst_ready", 64'(bus.div_i_ready), 64'd1);
        exp_q.delete();
        @(posedge clk); @(negedge clk);
        rst = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, IW'($urandom), 7'($urandom), $urandom,
                 $urandom_range(0, 9) == 0, RL'($urandom), $urandom_range(0, 1) == 1, p);
        end
        idle(10, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
